// File: rtl/csa_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
// Ports: clk, rst_n | in_valid/in_ready, a, b, sub, cin | out_valid/out_ready, sum, c_out, overflow, zero.
// WIDTH must be a multiple of BLOCK, with at least two blocks.
module csa_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NB = WIDTH / BLOCK;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    // Block 0 of s1_sum0 is final; upper blocks hold the cin=0 candidate.
    logic [WIDTH-1:0]     s1_sum0_q, s1_sum0_d;
    logic [WIDTH-1:BLOCK] s1_sum1_q, s1_sum1_d;
    // Bit 0 of s1_cy0 is the real carry out of block 0.
    logic [NB-1:0]    s1_cy0_q, s1_cy0_d;
    logic [NB-1:1]    s1_cy1_q, s1_cy1_d;
    logic             s1_amsb_q, s1_amsb_d;
    logic             s1_bmsb_q, s1_bmsb_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic             s2_cout_q, s2_cout_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_zero_q, s2_zero_d;

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic             s2_adv;
    logic             accept;
    logic             advance;
    logic [BLOCK:0]   blk0;
    logic [BLOCK:0]   blk1;
    logic [WIDTH-1:0] res;
    logic             k;

    always_comb begin
        bb      = sub ? ~b : b;
        c0      = sub | cin;
        s2_adv  = out_ready | ~s2_valid_q;
        in_ready = ~s1_valid_q | s2_adv;
        accept  = in_valid & in_ready;
        advance = s1_valid_q & s2_adv;
    end

    // Stage 1: per-block candidate sums for both possible carry-ins.
    always_comb begin
        s1_sum0_d = s1_sum0_q;
        s1_sum1_d = s1_sum1_q;
        s1_cy0_d  = s1_cy0_q;
        s1_cy1_d  = s1_cy1_q;
        s1_amsb_d = s1_amsb_q;
        s1_bmsb_d = s1_bmsb_q;
        blk0      = '0;
        blk1      = '0;
        if (accept) begin
            blk0 = {1'b0, a[BLOCK-1:0]} + {1'b0, bb[BLOCK-1:0]}
                 + {{BLOCK{1'b0}}, c0};
            s1_sum0_d[BLOCK-1:0] = blk0[BLOCK-1:0];
            s1_cy0_d[0]          = blk0[BLOCK];
            for (int i = 1; i < NB; i++) begin
                blk0 = {1'b0, a[i*BLOCK +: BLOCK]}
                     + {1'b0, bb[i*BLOCK +: BLOCK]};
                blk1 = blk0 + {{BLOCK{1'b0}}, 1'b1};
                s1_sum0_d[i*BLOCK +: BLOCK] = blk0[BLOCK-1:0];
                s1_sum1_d[i*BLOCK +: BLOCK] = blk1[BLOCK-1:0];
                s1_cy0_d[i] = blk0[BLOCK];
                s1_cy1_d[i] = blk1[BLOCK];
            end
            s1_amsb_d = a[WIDTH-1];
            s1_bmsb_d = bb[WIDTH-1];
        end
        s1_valid_d = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    end

    // Stage 2: ripple the block carries through the select muxes.
    always_comb begin
        k   = s1_cy0_q[0];
        res = s1_sum0_q;
        for (int i = 1; i < NB; i++) begin
            res[i*BLOCK +: BLOCK] = k ? s1_sum1_q[i*BLOCK +: BLOCK]
                                      : s1_sum0_q[i*BLOCK +: BLOCK];
            k = k ? s1_cy1_q[i] : s1_cy0_q[i];
        end
        s2_sum_d  = s2_sum_q;
        s2_cout_d = s2_cout_q;
        s2_ovf_d  = s2_ovf_q;
        s2_zero_d = s2_zero_q;
        if (advance) begin
            s2_sum_d  = res;
            s2_cout_d = k;
            s2_ovf_d  = (s1_amsb_q == s1_bmsb_q) &&
                        (res[WIDTH-1] != s1_amsb_q);
            s2_zero_d = ~|res;
        end
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_sum0_q  <= '0;
            s1_sum1_q  <= '0;
            s1_cy0_q   <= '0;
            s1_cy1_q   <= '0;
            s1_amsb_q  <= 1'b0;
            s1_bmsb_q  <= 1'b0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_sum0_q  <= s1_sum0_d;
            s1_sum1_q  <= s1_sum1_d;
            s1_cy0_q   <= s1_cy0_d;
            s1_cy1_q   <= s1_cy1_d;
            s1_amsb_q  <= s1_amsb_d;
            s1_bmsb_q  <= s1_bmsb_d;
            s2_sum_q   <= s2_sum_d;
            s2_cout_q  <= s2_cout_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = s2_sum_q;
    assign c_out     = s2_cout_q;
    assign overflow  = s2_ovf_q;
    assign zero      = s2_zero_q;

endmodule

// File: tb/tb_csa_adder_pipe.sv
// Directed testbench for csa_adder_pipe.
// Checks latency, streaming, backpressure, mid-flight reset and two extra widths.
module tb_csa_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, sub, cin;
    logic        out_valid, out_ready, c_out, overflow, zero;
    logic [31:0] a, b, sum;

    logic        iv16, ir16, sub16, cin16, ov16, or16, c16, f16, z16;
    logic [15:0] a16, b16, s16;
    logic        iv64, ir64, sub64, cin64, ov64, or64, c64, f64, z64;
    logic [63:0] a64, b64, s64;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out;
    int q[$];

    always #5 clk = ~clk;

    csa_adder_pipe #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out),
        .overflow(overflow), .zero(zero)
    );

    csa_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(sub16), .cin(cin16), .out_valid(ov16),
        .out_ready(or16), .sum(s16), .c_out(c16),
        .overflow(f16), .zero(z16)
    );

    csa_adder_pipe #(.WIDTH(64), .BLOCK(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .sub(sub64), .cin(cin64), .out_valid(ov64),
        .out_ready(or64), .sum(s64), .c_out(c64),
        .overflow(f64), .zero(z64)
    );

    // Hand-computed vectors: a, b, sub, cin -> sum, c_out, overflow, zero.
    logic [31:0] va [8] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h7,
                            32'hFF, 32'h8000_0000, 32'hA, 32'h8000_0000};
    logic [31:0] vb [8] = '{32'h1, 32'h1, 32'h7, 32'h5,
                            32'h0, 32'h1, 32'hA, 32'h8000_0000};
    logic        vs [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
    logic        vc [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic [31:0] es [8] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h2,
                            32'h100, 32'h7FFF_FFFF, 32'h0, 32'h0};
    logic        ec [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    logic        eo [8] = '{0, 1, 0, 0, 0, 1, 0, 1};
    logic        ez [8] = '{1, 0, 0, 0, 0, 0, 1, 1};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle on the 32-bit DUT with a scoreboard of vector indices.
    task automatic step(input bit drv, input int idx, input bit ordy,
                        output bit acc);
        in_valid  = drv;
        out_ready = ordy;
        if (drv) begin
            a = va[idx]; b = vb[idx]; sub = vs[idx]; cin = vc[idx];
        end
        #1;
        acc = in_valid && in_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("q_sum", sum, es[q[0]]);
                chk("q_cout", c_out, ec[q[0]]);
                chk("q_ovf", overflow, eo[q[0]]);
                chk("q_zero", zero, ez[q[0]]);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (acc) q.push_back(idx);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb,
                        input logic ts, input logic tc, input logic [15:0] xs,
                        input logic xc, input logic xo, input logic xz);
        iv16 = 1; a16 = ta; b16 = tb; sub16 = ts; cin16 = tc;
        @(posedge clk); @(negedge clk);
        iv16 = 0;
        @(posedge clk); @(negedge clk);
        chk("w16_valid", ov16, 1);
        chk("w16_sum", s16, xs);
        chk("w16_cout", c16, xc);
        chk("w16_ovf", f16, xo);
        chk("w16_zero", z16, xz);
    endtask

    task automatic op64(input logic [63:0] ta, input logic [63:0] tb,
                        input logic ts, input logic tc, input logic [63:0] xs,
                        input logic xc, input logic xo, input logic xz);
        iv64 = 1; a64 = ta; b64 = tb; sub64 = ts; cin64 = tc;
        @(posedge clk); @(negedge clk);
        iv64 = 0;
        @(posedge clk); @(negedge clk);
        chk("w64_valid", ov64, 1);
        chk("w64_sum", s64, xs);
        chk("w64_cout", c64, xc);
        chk("w64_ovf", f64, xo);
        chk("w64_zero", z64, xz);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i;
        in_valid = 0; out_ready = 0; a = 0; b = 0; sub = 0; cin = 0;
        iv16 = 0; or16 = 1; a16 = 0; b16 = 0; sub16 = 0; cin16 = 0;
        iv64 = 0; or64 = 1; a64 = 0; b64 = 0; sub64 = 0; cin64 = 0;

        // Reset then idle
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_zero", zero, 0);
        rst_n = 1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Latency of a single operation
        in_valid = 1; out_ready = 1;
        a = va[0]; b = vb[0]; sub = vs[0]; cin = vc[0];
        #1 chk("lat_in_ready", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        #1 chk("lat_early", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_sum", sum, 32'h0);
        chk("lat_cout", c_out, 1);
        chk("lat_zero", zero, 1);
        chk("lat_ovf", overflow, 0);
        @(posedge clk); @(negedge clk);
        chk("lat_drop", out_valid, 0);

        // Back-to-back stream
        n_out = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, k, 1, acc);
            chk("stream_acc", acc, 1);
        end
        for (int c = 0; c < 6 && q.size() > 0; c++) step(0, 0, 1, acc);
        chk("stream_count", n_out, 8);

        // Backpressure: exactly two accepts, then stall
        n_out = 0;
        i = 0;
        repeat (6) begin
            step(1, i, 0, acc);
            if (acc) i++;
        end
        chk("bp_accepts", i, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", n_out, 0);
        // Consume and accept on the same edge while full
        step(1, i, 1, acc);
        chk("full_accept", acc, 1);
        if (acc) i++;
        for (int c = 0; c < 30 && (i < 8 || q.size() > 0); c++) begin
            if (i < 8) begin
                step(1, i, 1, acc);
                if (acc) i++;
            end else begin
                step(0, 0, 1, acc);
            end
        end
        chk("bp_drained", n_out, 8);
        chk("bp_queue", q.size(), 0);

        // Mid-flight reset with both stages full
        step(1, 1, 0, acc);
        step(1, 2, 0, acc);
        chk("mr_full", out_valid, 1);
        rst_n = 0;
        #1 chk("mr_valid", out_valid, 0);
        chk("mr_sum", sum, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        q.delete();
        in_valid = 0; out_ready = 1;
        repeat (4) begin
            #1 chk("mr_quiet", out_valid, 0);
            @(posedge clk); @(negedge clk);
        end

        // Width sweep
        op16(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        op16(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        op16(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0, 0);
        op16(16'h00FF, 16'h0F01, 0, 0, 16'h1000, 0, 0, 0);
        op16(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 0);
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1);
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0,
             64'h8000_0000_0000_0000, 0, 1, 0);
        op64(64'h5, 64'h7, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        op64(64'h0000_0000_FFFF_FFFF, 64'h0, 0, 1,
             64'h0000_0001_0000_0000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_adder_pipe.md
Name: csa_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-select adder/subtractor; successor to the fixed 32-bit combinational carry-select adder.
- Generalised in width and block size. Adds subtract mode, carry-in, status flags (carry, signed overflow, zero) and valid/ready flow control with backpressure.
- Sits between the ALU operand muxes and the result writeback path. Used where the full-width carry chain must be split across a register boundary.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, carry-select block width in bits; NB = WIDTH/BLOCK blocks, NB >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a/b/sub/cin are valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A - B, 0 = A + B + cin.
- cin  in  1  carry-in for add mode; ignored when sub=1.
- out_valid  out  1  result outputs are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB; in subtract mode 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0: s1_valid=0, s2_valid=0, all stage registers 0; outputs out_valid=0, sum=0, c_out=0, overflow=0, zero=0. in_ready=1 once rst_n=1.
- Operand prep (combinational, at input): bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1 (registered on accept):
  - Block 0 computes a[BLOCK-1:0]+bb[BLOCK-1:0]+c0 and registers sum0 and carry k0.
  - Each block i >= 1 registers two candidates: (sum, carry) with carry-in 0 and with carry-in 1.
  - Also registers the MSBs of a and bb for the overflow calculation.
- Stage 2 (registered on advance):
  - Resolve the select chain: k_i = k_(i-1) ? carry1_i : carry0_i; block i sum = k_(i-1) ? sum1_i : sum0_i.
  - c_out = k_(NB-1).
  - overflow = (a_msb == bb_msb) && (sum_msb != a_msb).
  - zero = ~|sum.
  - All four result outputs come directly from stage-2 registers.
- Latency: a result appears on out_valid exactly 2 cycles after the accepting edge when there is no backpressure. Throughput is 1 operation per cycle.
- Handshake:
  - s2_adv = out_ready || !s2_valid.
  - in_ready = !s1_valid || s2_adv (combinational; depends on out_ready).
  - Input is accepted on an edge with in_valid && in_ready.
  - s1 moves into s2 on an edge with s1_valid && s2_adv.
  - out_valid = s2_valid.
  - Result is consumed on an edge with out_valid && out_ready.
- Valid-bit updates:
  - s1_valid next = accept ? 1 : (s2_adv ? 0 : s1_valid).
  - s2_valid next = s2_adv ? s1_valid : s2_valid.
- Stall: while out_valid && !out_ready, sum/c_out/overflow/zero/out_valid hold stable. Stage 1 holds if occupied. With both stages full, in_ready=0. No operation is dropped or duplicated.
- Simultaneous consume and accept with both stages full: all three transfers happen on the same edge; the pipeline stays full.
- Reset mid-operation: all in-flight operations are discarded; no output is produced for them after reset release.
- Arithmetic rules:
  - Add wraps modulo 2^WIDTH.
  - Subtract equals a + ~b + 1, so c_out = (a >= b) unsigned.
  - Flags are meaningful only when out_valid=1.
- Data registers are not required to clear when their stage's valid bit is 0. Outputs are checked only when out_valid=1, except during reset.

Test Plan:
- Reset then idle: pulse rst_n low for 3 cycles with in_valid=0 -> out_valid=0, sum=0, all flags 0; in_ready=1 after release.
- Add with full carry ripple, WIDTH=32, BLOCK=8: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0, out_ready=1 -> two cycles later sum=0x00000000, c_out=1, zero=1, overflow=0.
- Signed overflow and subtract:
  - a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, c_out=0.
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
- Back-to-back stream: 8 random operations on consecutive cycles, out_ready=1 -> 8 results in order, one per cycle, starting 2 cycles after the first accept; each matches a golden model.
- Backpressure:
  - Hold out_ready=0 while driving in_valid=1 continuously -> exactly 2 accepts, then in_ready=0; outputs stay stable.
  - Raise out_ready -> results drain in order with no loss.
- Mid-flight reset plus parameter sweep:
  - Assert rst_n=0 with both stages full -> out_valid=0 immediately; nothing emitted after release.
  - Repeat the golden-model random test at WIDTH=16/BLOCK=4 and WIDTH=64/BLOCK=16.
